// File: rtl/pc_seq_pkg.sv
// pc_seq shared types and constants.
// Sequencer state, opcode field positions and jump-class decode.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_OPND1 = 2'd1,
        S_OPND2 = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    // Operand-count field of the opcode byte.
    localparam int OPC_CNT_HI = 7;
    localparam int OPC_CNT_LO = 6;

    // Jump-class opcodes: top three bits match this pattern.
    localparam logic [2:0] JMP_CLASS = 3'b101;

    // Number of operand bytes that follow an opcode.
    function automatic logic [1:0] opnd_count(input logic [7:0] op);
        logic [1:0] f;
        f = op[OPC_CNT_HI:OPC_CNT_LO];
        case (f)
            2'b01:   opnd_count = 2'd1;
            2'b10:   opnd_count = 2'd2;
            default: opnd_count = 2'd0;
        endcase
    endfunction

    function automatic logic is_jump(input logic [7:0] op);
        is_jump = (op[7:5] == JMP_CLASS);
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// pc_seq memory read bus.
// The sequencer is master: it requests at address pc, memory answers.
interface pc_seq_if;
    logic       mem_req;
    logic [7:0] pc;
    logic [7:0] databus;
    logic       mem_ack;

    modport master (
        output mem_req,
        output pc,
        input  databus,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  pc,
        output databus,
        output mem_ack
    );
endinterface

// File: rtl/pc_seq.sv
// pc_seq: fetch/operand/execute program-counter sequencer.
// Fetches an opcode plus up to two operand bytes, then executes one cycle.
module pc_seq
    import pc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    pc_seq_if.master   bus,
    input  logic       halt,
    input  logic       jmp_take,
    input  logic [7:0] jmp_addr,
    output logic [7:0] ir,
    output logic [7:0] opnd_lo,
    output logic [7:0] opnd_hi,
    output logic       jmp_oe,
    output logic       exec
);

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic       req_c;
    logic       exec_c;
    logic       jmp_c;

    // Next-state, next-register and strobe decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        req_c   = 1'b0;
        exec_c  = 1'b0;
        jmp_c   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (!halt) begin
                    req_c = 1'b1;
                    if (bus.mem_ack) begin
                        ir_d = bus.databus;
                        pc_d = pc_q + 8'd1;
                        if (opnd_count(bus.databus) == 2'd0)
                            state_d = S_EXEC;
                        else
                            state_d = S_OPND1;
                    end
                end
            end
            S_OPND1: begin
                req_c = 1'b1;
                if (bus.mem_ack) begin
                    lo_d = bus.databus;
                    pc_d = pc_q + 8'd1;
                    if (opnd_count(ir_q) == 2'd2)
                        state_d = S_OPND2;
                    else
                        state_d = S_EXEC;
                end
            end
            S_OPND2: begin
                req_c = 1'b1;
                if (bus.mem_ack) begin
                    hi_d    = bus.databus;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_c  = 1'b1;
                jmp_c   = is_jump(ir_q);
                if (jmp_c && jmp_take)
                    pc_d = jmp_addr;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural registers; reset clears them without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Strobes are forced quiet while reset is held.
    assign bus.mem_req = req_c & ~reset;
    assign exec        = exec_c & ~reset;
    assign jmp_oe      = jmp_c & ~reset;
    assign bus.pc      = pc_q;
    assign ir          = ir_q;
    assign opnd_lo     = lo_q;
    assign opnd_hi     = hi_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed and random stimulus for pc_seq.
// Outputs are checked each cycle against an instruction-level model.
module tb_pc_seq;

    logic       clk;
    logic       reset;
    logic       halt;
    logic       jmp_take;
    logic [7:0] jmp_addr;
    logic [7:0] ir;
    logic [7:0] opnd_lo;
    logic [7:0] opnd_hi;
    logic       jmp_oe;
    logic       exec;

    pc_seq_if bus ();

    pc_seq dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.master),
        .halt     (halt),
        .jmp_take (jmp_take),
        .jmp_addr (jmp_addr),
        .ir       (ir),
        .opnd_lo  (opnd_lo),
        .opnd_hi  (opnd_hi),
        .jmp_oe   (jmp_oe),
        .exec     (exec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Instruction-level model: bytes still owed, and whether executing.
    int         ncount [4] = '{0, 1, 2, 0};
    logic [7:0] m_pc, m_ir, m_lo, m_hi;
    int         m_got;
    int         m_need;
    bit         m_exec;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h want %02h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic bit jump_op(input logic [7:0] op);
        return (op >= 8'hA0) && (op <= 8'hBF);
    endfunction

    task automatic model_clear();
        m_pc   = 8'h00;
        m_ir   = 8'h00;
        m_lo   = 8'h00;
        m_hi   = 8'h00;
        m_got  = 0;
        m_need = 0;
        m_exec = 1'b0;
    endtask

    // Drive one cycle of inputs, check outputs, advance the model.
    task automatic drive_chk(input logic [7:0] db, input logic ack,
                             input logic h, input logic tk,
                             input logic [7:0] ta);
        bit fetching;
        bus.databus = db;
        bus.mem_ack = ack;
        halt        = h;
        jmp_take    = tk;
        jmp_addr    = ta;
        #1;
        fetching = !m_exec && (m_got == 0);
        chk("pc", bus.pc, m_pc);
        chk("ir", ir, m_ir);
        chk("opnd_lo", opnd_lo, m_lo);
        chk("opnd_hi", opnd_hi, m_hi);
        chk("exec", {7'd0, exec}, {7'd0, m_exec});
        chk("jmp_oe", {7'd0, jmp_oe}, {7'd0, m_exec && jump_op(m_ir)});
        chk("mem_req", {7'd0, bus.mem_req},
            {7'd0, !m_exec && !(fetching && h)});
        if (m_exec) begin
            if (jump_op(m_ir) && tk)
                m_pc = ta;
            m_exec = 1'b0;
        end else if (fetching) begin
            if (!h && ack) begin
                m_ir   = db;
                m_need = ncount[db >> 6];
                m_pc   = m_pc + 8'd1;
                if (m_need == 0) m_exec = 1'b1;
                else m_got = 1;
            end
        end else if (ack) begin
            if (m_got == 1) m_lo = db;
            else m_hi = db;
            m_pc = m_pc + 8'd1;
            if (m_got == m_need) begin
                m_exec = 1'b1;
                m_got  = 0;
            end else begin
                m_got++;
            end
        end
    endtask

    task automatic cyc(input logic [7:0] db, input logic ack,
                       input logic h, input logic tk,
                       input logic [7:0] ta);
        @(negedge clk);
        drive_chk(db, ack, h, tk, ta);
    endtask

    // Reset mid low-phase, check async clear, then fetch opcode 00 at 00.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_pc", bus.pc, 8'h00);
        chk("rst_ir", ir, 8'h00);
        chk("rst_lo", opnd_lo, 8'h00);
        chk("rst_hi", opnd_hi, 8'h00);
        chk("rst_req", {7'd0, bus.mem_req}, 8'h00);
        chk("rst_exec", {7'd0, exec}, 8'h00);
        chk("rst_jmp", {7'd0, jmp_oe}, 8'h00);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        drive_chk(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    // Jump-class instruction from FETCH through EXEC.
    task automatic run_jmp(input logic [7:0] lo, input logic [7:0] hi,
                           input logic tk, input logic [7:0] ta);
        cyc(8'hA0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(lo, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(hi, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(8'h00, 1'b1, 1'b0, tk, ta);
        chk("jmp_oe_pulse", {7'd0, jmp_oe}, 8'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        halt        = 1'b0;
        jmp_take    = 1'b0;
        jmp_addr    = 8'h00;
        bus.databus = 8'h00;
        bus.mem_ack = 1'b0;
        model_clear();

        apply_reset();

        // Zero-operand stream: two cycles per instruction.
        cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("stream_exec", {7'd0, exec}, 8'h01);
        for (int i = 0; i < 4; i++)
            cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("stream_pc", bus.pc, 8'h03);

        // Taken jump to 10, then taken jump to 40.
        run_jmp(8'h10, 8'h00, 1'b1, 8'h10);
        run_jmp(8'h34, 8'h12, 1'b1, 8'h40);
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("taken_pc", bus.pc, 8'h40);
        chk("taken_lo", opnd_lo, 8'h34);
        chk("taken_hi", opnd_hi, 8'h12);
        chk("taken_oe_off", {7'd0, jmp_oe}, 8'h00);

        // Not-taken jump at 10 falls through to 13.
        run_jmp(8'h10, 8'h00, 1'b1, 8'h10);
        run_jmp(8'h34, 8'h12, 1'b0, 8'h40);
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("fall_pc", bus.pc, 8'h13);

        // Wrap from FF.
        run_jmp(8'h00, 8'h00, 1'b1, 8'hFF);
        cyc(8'h40, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(8'h55, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("wrap_pc0", bus.pc, 8'h00);
        cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("wrap_pc1", bus.pc, 8'h01);
        chk("wrap_lo", opnd_lo, 8'h55);

        // Operand wait states, then halt in FETCH.
        cyc(8'h40, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++)
            cyc(8'hEE, 1'b0, 1'b1, 1'b1, 8'h77);
        chk("wait_pc", bus.pc, 8'h02);
        cyc(8'h77, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++)
            cyc(8'hA0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("halt_req", {7'd0, bus.mem_req}, 8'h00);
        chk("halt_pc", bus.pc, 8'h03);

        // Reset while in OPND2.
        cyc(8'hA0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(8'h34, 1'b1, 1'b0, 1'b0, 8'h00);
        apply_reset();

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                apply_reset();
            end else begin
                cyc(8'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) == 0, 1'($urandom),
                    8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
